om_result_drain: RTL and testbench
==================================

Name: om_result_drain

Overview:
Reads the per-node distance results that bellmanford wrote into OutputMemory and streams them out of the design over a valid/ready interface, one 16-bit word per accepted transfer.
It is the reader end of the OutputMemory write path (OMWAR/OMWDR/OMWE), and it drives the read port (OMAR/OMDR).
It sits beside bellmanford and is started by the top level after the algorithm finishes.
It also latches NegCycle so the consumer can qualify the stream.

Parameters:
ADDR_W, 13, OutputMemory address width (matches OMAR)
DATA_W, 16, OutputMemory word width (matches OMDR)
BASE_ADDR, 0, first OutputMemory address of the result array

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a drain; ignored unless idle
num_nodes  input  ADDR_W  number of words to drain; sampled on accepted start
neg_cycle_in  input  1  NegCycle from bellmanford; sampled on accepted start
OMAR  output  ADDR_W  OutputMemory read address
OMDR  input  DATA_W  OutputMemory read data, combinational from OMAR (same cycle)
out_valid  output  1  out_data/out_index/out_last are valid
out_ready  input  1  consumer accepts the word when out_valid & out_ready
out_data  output  DATA_W  distance word
out_index  output  ADDR_W  node index of out_data (0-based, relative to BASE_ADDR)
out_last  output  1  current word is the final word of the drain
neg_flag  output  1  latched neg_cycle_in of the current or most recent drain
busy  output  1  high from accepted start until the done pulse
done  output  1  one-cycle pulse when the drain completes

Behaviour:
- Reset values: all outputs 0, OMAR = BASE_ADDR, state IDLE, counters 0. Reset mid-drain aborts immediately; no done pulse is generated.
- States:
  - IDLE: start -> latch count = num_nodes and neg_flag = neg_cycle_in, set rd_ptr = 0, go to STREAM, busy = 1. If num_nodes == 0, go straight to FIN instead.
  - STREAM: the output register loads when (!out_valid | out_ready) and rd_ptr < count.
    - Load captures out_data = OMDR, out_index = rd_ptr, out_last = (rd_ptr == count-1), then increments rd_ptr.
    - If out_valid & out_ready and no load occurs, out_valid drops.
    - Go to FIN on the handshake of the word with out_last = 1.
  - FIN: done = 1 for exactly one cycle, busy = 0, out_valid = 0, return to IDLE.
- OMAR = BASE_ADDR + rd_ptr, combinational from a register. Address arithmetic is ADDR_W bits with wrap-around; no error flag.
- Latency:
  - Start sampled at edge k -> out_valid first high after edge k+1.
  - With out_ready held high, one word per cycle and no bubbles.
  - Last handshake at edge m -> done high during the cycle after edge m.
- Handshake rules:
  - Once out_valid is high, out_data, out_index and out_last hold stable until the handshake.
  - out_valid never drops without a handshake, except on reset.
- start while busy or in FIN: ignored; count and neg_flag are unchanged.
- neg_flag holds its value after done until the next accepted start.
- The drain must be started only after bellmanford stops writing (OMWE low). The block does not arbitrate against OMWE.

Decomposition:
- Shared package: state encoding (IDLE, STREAM, FIN), ADDR_W/DATA_W defaults, and BASE_ADDR constant shared with bellmanford's output layout.
- No sub-module needed; a single FSM plus a one-entry output register.

Test Plan:
- Preload OutputMemory[0..3] = 0000, 0005, 0003, 0009; num_nodes = 4; out_ready = 1 -> four transfers in consecutive cycles, index 0..3, data 0000/0005/0003/0009, out_last only on index 3, done one cycle later.
- Same memory contents, out_ready toggling 1,0,0,1,... -> identical sequence; data and index stable while stalled; no duplicated or dropped word.
- num_nodes = 0 with start -> out_valid never asserts; done pulses in the cycle after the start edge; busy is high for exactly that one cycle.
- neg_cycle_in = 1 at start, num_nodes = 2 -> neg_flag = 1 throughout the drain and after done. A second drain with neg_cycle_in = 0 clears it at that start.
- Second start pulse mid-drain with num_nodes = 7 -> ignored; original count of 4 completes unchanged.
- Assert reset after the 2nd transfer -> all outputs 0 immediately. A new start drains from index 0 with the correct data.

Source files
------------

// File: rtl/om_result_drain_pkg.sv
// Shared types and defaults for the OutputMemory result drain.
// BASE_ADDR must match the layout bellmanford uses when writing results.
package om_result_drain_pkg;

    localparam int DEF_ADDR_W    = 13;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_BASE_ADDR = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FIN    = 2'd2
    } state_t;

endpackage

// File: rtl/om_result_drain_if.sv
// Valid/ready result stream carrying one distance word per transfer.
interface om_result_drain_if
    import om_result_drain_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;

    modport master (
        output out_valid,
        input  out_ready,
        output out_data,
        output out_index,
        output out_last
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_index,
        input  out_last
    );
endinterface

// File: rtl/om_result_drain.sv
// Streams the bellmanford distance array out of OutputMemory over valid/ready,
// with a one-entry output register and a latched NegCycle qualifier.
module om_result_drain
    import om_result_drain_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_nodes,
    input  logic              neg_cycle_in,
    output logic [ADDR_W-1:0] OMAR,
    input  logic [DATA_W-1:0] OMDR,
    om_result_drain_if.master strm,
    output logic              neg_flag,
    output logic              busy,
    output logic              done
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] count_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic              neg_flag_reg;
    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;
    logic [ADDR_W-1:0] index_reg;
    logic              last_reg;

    logic accept;
    logic fire;
    logic load;

    assign accept = (state_reg == ST_IDLE) && start;
    assign fire   = valid_reg && strm.out_ready;
    // Refill whenever the slot is empty or being emptied this cycle.
    assign load   = (state_reg == ST_STREAM) && (!valid_reg || strm.out_ready)
                    && (rd_ptr_reg < count_reg);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (num_nodes == '0) ? ST_FIN : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (fire && last_reg) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // A zero-length drain never visits STREAM, so busy is shown alongside done.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            ST_STREAM: busy = 1'b1;
            ST_FIN: begin
                done = 1'b1;
                busy = (count_reg == '0);
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            neg_flag_reg <= 1'b0;
            valid_reg    <= 1'b0;
            data_reg     <= '0;
            index_reg    <= '0;
            last_reg     <= 1'b0;
        end else begin
            if (accept) begin
                count_reg    <= num_nodes;
                neg_flag_reg <= neg_cycle_in;
                rd_ptr_reg   <= '0;
            end
            if (load) begin
                valid_reg  <= 1'b1;
                data_reg   <= OMDR;
                index_reg  <= rd_ptr_reg;
                last_reg   <= (rd_ptr_reg == count_reg - ADDR_W'(1));
                rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
            end else if (fire) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign OMAR           = ADDR_W'(BASE_ADDR) + rd_ptr_reg;
    assign neg_flag       = neg_flag_reg;
    assign strm.out_valid = valid_reg;
    assign strm.out_data  = data_reg;
    assign strm.out_index = index_reg;
    assign strm.out_last  = last_reg;

endmodule

// File: tb/tb_om_result_drain.sv
// Directed bench for om_result_drain: memory model on the read port, scripted
// ready patterns, and one checking task for every comparison.
module tb_om_result_drain;
    import om_result_drain_pkg::*;

    localparam int AW = 13;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] num_nodes = '0;
    logic          neg_cycle_in = 1'b0;
    logic [AW-1:0] OMAR;
    logic [DW-1:0] OMDR;
    logic          neg_flag;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [0:15];
    int total = 0;
    int bad   = 0;

    om_result_drain_if #(.ADDR_W(AW), .DATA_W(DW)) sif ();

    om_result_drain #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(0)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .num_nodes    (num_nodes),
        .neg_cycle_in (neg_cycle_in),
        .OMAR         (OMAR),
        .OMDR         (OMDR),
        .strm         (sif),
        .neg_flag     (neg_flag),
        .busy         (busy),
        .done         (done)
    );

    assign OMDR = mem[OMAR[3:0]];

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input int n, input logic neg);
        start        = 1'b1;
        num_nodes    = AW'(n);
        neg_cycle_in = neg;
        step();
        start        = 1'b0;
        neg_cycle_in = 1'b0;
        check_val("busy_after_start", busy, 1);
        check_val("valid_after_start", sif.out_valid, 0);
        check_val("neg_latch", neg_flag, neg);
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1,...
    task automatic drain(input int n, input int mode, input logic neg_exp, input bit inj);
        int            got = 0;
        int            last_fire = -10;
        bit            held = 0;
        bit            fin = 0;
        logic [DW-1:0] hd = '0;
        logic [AW-1:0] hi = '0;
        logic          rdy;
        for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
            step();
            if (inj) begin
                if (cyc == 2) begin
                    start = 1'b1; num_nodes = AW'(7); neg_cycle_in = ~neg_exp;
                end else begin
                    start = 1'b0; neg_cycle_in = 1'b0;
                end
            end
            if (cyc == 1) check_val("first_valid", sif.out_valid, 1);
            check_val("neg_flag", neg_flag, neg_exp);
            if (sif.out_valid) begin
                if (held) begin
                    check_val("stable_data", sif.out_data, hd);
                    check_val("stable_index", sif.out_index, hi);
                end
                check_val("index", sif.out_index, got);
                check_val("data", sif.out_data, mem[got]);
                check_val("last", sif.out_last, (got == n - 1));
            end else if (mode == 0 && got < n && !done) begin
                check_val("bubble", sif.out_valid, 1);
            end
            if (done) begin
                fin = 1;
                check_val("count", got, n);
                check_val("done_lat", cyc, last_fire + 1);
                check_val("busy_fin", busy, 0);
                check_val("valid_fin", sif.out_valid, 0);
            end else begin
                check_val("busy", busy, 1);
                rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 1);
                sif.out_ready = rdy;
                held = sif.out_valid && !rdy;
                hd = sif.out_data;
                hi = sif.out_index;
                if (sif.out_valid && rdy) begin
                    $display("xfer idx=%0d data=%h last=%0b neg=%0b",
                             sif.out_index, sif.out_data, sif.out_last, neg_flag);
                    got++;
                    last_fire = cyc;
                end
            end
        end
        if (!fin) check_val("timeout", 0, 1);
        start = 1'b0;
        step();
        check_val("done_pulse", done, 0);
        check_val("neg_hold", neg_flag, neg_exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'hdead;
        mem[0] = 16'h0000;
        mem[1] = 16'h0005;
        mem[2] = 16'h0003;
        mem[3] = 16'h0009;
        sif.out_ready = 1'b0;

        #3;
        check_val("rst_valid", sif.out_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_neg", neg_flag, 0);
        check_val("rst_omar", OMAR, 0);
        check_val("rst_data", sif.out_data, 0);
        step();
        reset = 1'b0;

        // Four words back to back
        sif.out_ready = 1'b1;
        do_start(4, 1'b0);
        drain(4, 0, 1'b0, 1'b0);

        // Same data with a stalling consumer
        do_start(4, 1'b0);
        drain(4, 1, 1'b0, 1'b0);

        // Zero-length drain
        start = 1'b1; num_nodes = '0; neg_cycle_in = 1'b0;
        step();
        start = 1'b0;
        check_val("zero_done", done, 1);
        check_val("zero_busy", busy, 1);
        check_val("zero_valid", sif.out_valid, 0);
        step();
        check_val("zero_done_off", done, 0);
        check_val("zero_busy_off", busy, 0);
        check_val("zero_valid_off", sif.out_valid, 0);

        // NegCycle latched, then cleared by the next start; mid-drain start ignored
        sif.out_ready = 1'b1;
        do_start(2, 1'b1);
        drain(2, 0, 1'b1, 1'b0);
        do_start(4, 1'b0);
        drain(4, 0, 1'b0, 1'b1);

        // Reset after the second transfer, then a clean restart
        sif.out_ready = 1'b1;
        do_start(4, 1'b0);
        step();
        step();
        step();
        check_val("pre_rst_index", sif.out_index, 2);
        #2;
        reset = 1'b1;
        #1;
        check_val("mid_rst_valid", sif.out_valid, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_done", done, 0);
        check_val("mid_rst_omar", OMAR, 0);
        check_val("mid_rst_index", sif.out_index, 0);
        check_val("mid_rst_last", sif.out_last, 0);
        check_val("mid_rst_data", sif.out_data, 0);
        step();
        reset = 1'b0;
        check_val("post_rst_done", done, 0);
        do_start(4, 1'b0);
        drain(4, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
